// File: rtl/lcm_pkg.sv
// Shared definitions for the LCM unit: default width, step-counter width, FSM states.
package lcm_pkg;

    localparam int unsigned LCM_WIDTH  = 16;
    localparam int unsigned LCM_STEP_W = $clog2(LCM_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } lcm_state_t;

    // Width of a counter that walks 0..w-1 (at least one bit).
    function automatic int unsigned step_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first, WIDTH cycles after start.
// The remainder port exists only when LCM_DIV_CHECK_EN is defined.
module seq_divider
    import lcm_pkg::*;
#(
    parameter int unsigned WIDTH = LCM_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
`ifdef LCM_DIV_CHECK_EN
    output logic [WIDTH:0]   remainder,
`endif
    output logic             done_c
);

    localparam int unsigned SW = step_width(WIDTH);

    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [SW-1:0]    cnt_q;
    logic             run_q;

    logic [WIDTH+1:0] shifted_c;
    logic [WIDTH+1:0] diff_c;
    logic             fits_c;

    // Trial subtraction of the divisor from the shifted partial remainder.
    always_comb begin
        shifted_c = {rem_q, quo_q[WIDTH-1]};
        diff_c    = shifted_c - {2'b00, dvs_q};
        fits_c    = ~diff_c[WIDTH+1];
        done_c    = run_q && (cnt_q == SW'(WIDTH - 1));
    end

    // Load operands on start, then retire one quotient bit per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            rem_q <= fits_c ? diff_c[WIDTH:0] : shifted_c[WIDTH:0];
            quo_q <= {quo_q[WIDTH-2:0], fits_c};
            cnt_q <= cnt_q + SW'(1);
            if (done_c) begin
                run_q <= 1'b0;
            end
        end
    end

    assign quotient = quo_q;
`ifdef LCM_DIV_CHECK_EN
    assign remainder = rem_q;
`endif

endmodule

// File: rtl/lcm_calculator.sv
// LCM unit downstream of the GCD engine: lcm = (a / gcd) * b via iterative divide then shift-add multiply.
// Optional build macro LCM_DIV_CHECK_EN flags a nonzero division remainder on err.
module lcm_calculator
    import lcm_pkg::*;
#(
    parameter int unsigned WIDTH = LCM_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   gcd,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] lcm,
    output logic               err
);

    localparam int unsigned SW = step_width(WIDTH);
    localparam int unsigned PW = 2 * WIDTH;

    lcm_state_t state_q, next_state;

    logic [WIDTH-1:0] a_cap_q, b_cap_q, g_cap_q;
    logic             v_d_q;
    logic [SW-1:0]    mstep_q;
    logic [PW-1:0]    mcand_q;
    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    acc_nxt_c;
    logic [PW-1:0]    lcm_q;
    logic             busy_q;
    logic             done_q;

    logic             launch_c;
    logic             zero_c;
    logic             mul_last_c;
    logic             div_start_c;

    logic [WIDTH-1:0] div_quo;
    logic             div_done_c;
`ifdef LCM_DIV_CHECK_EN
    logic [WIDTH:0]   div_rem;
`endif

    seq_divider #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start_c),
        .dividend  (a_cap_q),
        .divisor   (g_cap_q),
        .quotient  (div_quo),
`ifdef LCM_DIV_CHECK_EN
        .remainder (div_rem),
`endif
        .done_c    (div_done_c)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    // Launch detection and next-state decode.
    always_comb begin
        next_state  = state_q;
        div_start_c = 1'b0;
        launch_c    = (state_q == IDLE) && v_d_q && !in_valid;
        zero_c      = (a_cap_q == '0) || (b_cap_q == '0) || (g_cap_q == '0);
        mul_last_c  = (state_q == MUL) && (mstep_q == SW'(WIDTH - 1));
        case (state_q)
            IDLE: begin
                if (launch_c) begin
                    if (zero_c) begin
                        next_state = DONE;
                    end else begin
                        next_state  = DIV;
                        div_start_c = 1'b1;
                    end
                end
            end
            DIV: begin
                if (div_done_c) begin
                    next_state = MUL;
                end
            end
            MUL: begin
                if (mul_last_c) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the current quotient bit is set.
    always_comb begin
        acc_nxt_c = acc_q + (div_quo[mstep_q] ? mcand_q : '0);
    end

    // Operand capture, multiplier datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_cap_q <= '0;
            b_cap_q <= '0;
            g_cap_q <= '0;
            v_d_q   <= 1'b0;
            mstep_q <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            lcm_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // Edges seen while busy are dropped, so v_d only tracks in_valid in IDLE.
            v_d_q <= (state_q == IDLE) ? in_valid : 1'b0;
            if ((state_q == IDLE) && in_valid) begin
                a_cap_q <= a;
                b_cap_q <= b;
                g_cap_q <= gcd;
            end

            busy_q <= (next_state != IDLE);
            done_q <= (next_state == DONE);

            if (launch_c) begin
                acc_q   <= '0;
                mcand_q <= {WIDTH'(0), b_cap_q};
                mstep_q <= '0;
            end else if (state_q == MUL) begin
                acc_q   <= acc_nxt_c;
                mcand_q <= mcand_q << 1;
                mstep_q <= mstep_q + SW'(1);
            end

            if (launch_c && zero_c) begin
                lcm_q <= '0;
            end else if (mul_last_c) begin
                lcm_q <= acc_nxt_c;
            end
        end
    end

`ifdef LCM_DIV_CHECK_EN
    logic err_q;

    // Flag an inexact division when the product is committed; cleared at every launch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (launch_c) begin
            err_q <= 1'b0;
        end else if (mul_last_c) begin
            err_q <= |div_rem;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy = busy_q;
    assign done = done_q;
    assign lcm  = lcm_q;

endmodule
